// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Brief    : AES key-length encoding, per-mode schedule constants, xtime and
//            the forward S-box table shared by the key schedule and round path.
// Revision : 1.0
// ============================================================================
package aes_pkg;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_EXPAND = 1'b1
   } state_t;

   localparam logic [1:0] c_klen_128 = 2'b00;
   localparam logic [1:0] c_klen_192 = 2'b01;
   localparam logic [1:0] c_klen_256 = 2'b10;

   localparam logic [3:0] c_nk_128 = 4'd4;
   localparam logic [3:0] c_nk_192 = 4'd6;
   localparam logic [3:0] c_nk_256 = 4'd8;

   localparam logic [3:0] c_nr_128 = 4'd10;
   localparam logic [3:0] c_nr_192 = 4'd12;
   localparam logic [3:0] c_nr_256 = 4'd14;

   localparam logic [5:0] c_nw_128 = 6'd44;
   localparam logic [5:0] c_nw_192 = 6'd52;
   localparam logic [5:0] c_nw_256 = 6'd60;

   localparam int c_idx_w = 6;

   // Byte 0x00 maps to the most significant byte of the table.
   localparam logic [2047:0] c_sbox_table = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [3:0] nk_of(input logic [1:0] key_len);
      case (key_len)
         c_klen_128: return c_nk_128;
         c_klen_192: return c_nk_192;
         c_klen_256: return c_nk_256;
         default:    return 4'd0;
      endcase
   endfunction

   function automatic logic [3:0] nr_of(input logic [1:0] key_len);
      case (key_len)
         c_klen_128: return c_nr_128;
         c_klen_192: return c_nr_192;
         c_klen_256: return c_nr_256;
         default:    return 4'd0;
      endcase
   endfunction

   function automatic logic [5:0] nw_of(input logic [1:0] key_len);
      case (key_len)
         c_klen_128: return c_nw_128;
         c_klen_192: return c_nw_192;
         c_klen_256: return c_nw_256;
         default:    return 6'd0;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [10:0] idx;
      idx = {~b, 3'b000};
      return c_sbox_table[idx +: 8];
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module   : aes_sbox
// Brief    : Combinational forward AES S-box for one byte.
// Revision : 1.0
// ============================================================================
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);

   assign o_byte = sbox(i_byte);

endmodule
`default_nettype wire

// File: rtl/aes_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_schedule
// Brief    : Iterative AES-128/192/256 key expansion, one word per clock, with
//            a registered 128-bit round-key read port.
// Revision : 1.0
// ============================================================================
module aes_key_schedule
   import aes_pkg::*;
#(
   parameter int MAX_KEY_BITS = 256
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [1:0]   key_len,
   input  logic [255:0] key_in,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic         keys_valid,
   output logic [3:0]   num_rounds,
   input  logic         rk_rd_en,
   input  logic [3:0]   rk_rd_round,
   output logic [127:0] rk_data,
   output logic         rk_valid
);

   localparam int c_max_nk = MAX_KEY_BITS >> 5;
   localparam int c_words  = 4 * (c_max_nk + 7);

   logic [31:0]        r_w [c_words];
   state_t             r_state;
   state_t             w_state_next;
   logic [c_idx_w-1:0] r_i;
   logic [c_idx_w-1:0] r_last;
   logic [2:0]         r_j;
   logic [3:0]         r_nk;
   logic [3:0]         r_nr;
   logic [7:0]         r_rcon;
   logic               r_done;
   logic               r_err;
   logic               r_keys_valid;
   logic [3:0]         r_num_rounds;
   logic [127:0]       r_rk_data;
   logic               r_rk_valid;

   logic [3:0]         w_nk_in;
   logic               w_legal;
   logic               w_accept;
   logic               w_reject;
   logic               w_last;
   logic [31:0]        w_prev;
   logic [31:0]        w_back;
   logic [31:0]        w_rot;
   logic [31:0]        w_sub;
   logic [31:0]        w_temp;
   logic [31:0]        w_new;
   logic               w_j_wrap;
   logic [c_idx_w-1:0] w_base;
   logic               w_rd_ok;

   assign w_nk_in = nk_of(key_len);
   assign w_legal = (w_nk_in != 4'd0) && (int'(w_nk_in) <= c_max_nk);

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_reject     = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (w_legal) begin
                  w_accept     = 1'b1;
                  w_state_next = ST_EXPAND;
               end else begin
                  w_reject = 1'b1;
               end
            end
         end
         ST_EXPAND: begin
            if (r_i == r_last) begin
               w_last       = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Word recurrence: w[i] = w[i-Nk] ^ f(w[i-1]).
   assign w_prev   = r_w[r_i - 6'd1];
   assign w_back   = r_w[r_i - {2'b00, r_nk}];
   assign w_rot    = (r_j == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
   assign w_j_wrap = ({1'b0, r_j} == (r_nk - 4'd1));

   for (genvar b = 0; b < 4; b++) begin : g_subword
      aes_sbox u_sbox (
         .i_byte (w_rot[8*b +: 8]),
         .o_byte (w_sub[8*b +: 8])
      );
   end

   always_comb begin
      w_temp = w_prev;
      if (r_j == 3'd0)
         w_temp = w_sub ^ {r_rcon, 24'h000000};
      else if ((r_nk == c_nk_256) && (r_j == 3'd4))
         w_temp = w_sub;
   end

   assign w_new   = w_back ^ w_temp;
   assign w_base  = {rk_rd_round, 2'b00};
   assign w_rd_ok = r_keys_valid && (r_state == ST_IDLE) && (rk_rd_round <= r_num_rounds);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         for (int k = 0; k < c_words; k++) r_w[k] <= '0;
         r_i          <= '0;
         r_last       <= '0;
         r_j          <= '0;
         r_nk         <= '0;
         r_nr         <= '0;
         r_rcon       <= '0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_keys_valid <= 1'b0;
         r_num_rounds <= '0;
         r_rk_data    <= '0;
         r_rk_valid   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_done  <= w_last;
         r_err   <= w_reject;

         if (w_accept) begin
            for (int k = 0; k < c_max_nk; k++) begin
               if (k < int'(w_nk_in)) r_w[k] <= key_in[255-32*k -: 32];
            end
            r_i          <= {2'b00, w_nk_in};
            r_j          <= '0;
            r_rcon       <= 8'h01;
            r_nk         <= w_nk_in;
            r_nr         <= nr_of(key_len);
            r_last       <= nw_of(key_len) - 6'd1;
            r_keys_valid <= 1'b0;
         end

         if (r_state == ST_EXPAND) begin
            r_w[r_i] <= w_new;
            r_i      <= r_i + 6'd1;
            r_j      <= w_j_wrap ? 3'd0 : r_j + 3'd1;
            if (r_j == 3'd0) r_rcon <= xtime(r_rcon);
         end

         if (w_last) begin
            r_keys_valid <= 1'b1;
            r_num_rounds <= r_nr;
         end

         r_rk_valid <= rk_rd_en;
         if (rk_rd_en) begin
            r_rk_data <= w_rd_ok ? {r_w[w_base], r_w[w_base + 6'd1],
                                    r_w[w_base + 6'd2], r_w[w_base + 6'd3]}
                                 : 128'h0;
         end
      end
   end

   assign busy       = (r_state == ST_EXPAND);
   assign done       = r_done;
   assign err        = r_err;
   assign keys_valid = r_keys_valid;
   assign num_rounds = r_num_rounds;
   assign rk_data    = r_rk_data;
   assign rk_valid   = r_rk_valid;

endmodule
`default_nettype wire

// File: doc/aes_key_schedule.md
# aes_key_schedule

Iterative AES key-schedule engine supporting AES-128/192/256, selected per operation. It produces one 32-bit schedule word per clock and holds the full expanded schedule in internal storage. A registered read port serves one 128-bit round key per request. It sits between the key-load path and the round datapath, replacing the former initial-time, 128-bit-only expansion.

## Interface
- MAX_KEY_BITS, 256, largest supported key size (128, 192 or 256); sizes word storage to 4*(MAX_NK+7) words
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to expand key_in
- key_len  in  2  00=128, 01=192, 10=256, 11 reserved
- key_in  in  256  key, MSB-aligned; w[0]=key_in[255:224], unused low bits ignored
- busy  out  1  expansion in progress
- done  out  1  one-cycle pulse when the schedule is complete
- err  out  1  one-cycle pulse on rejected start
- keys_valid  out  1  schedule complete and stable, cleared by next accepted start
- num_rounds  out  4  Nr of stored schedule (10/12/14), 0 after reset
- rk_rd_en  in  1  round-key read request
- rk_rd_round  in  4  round index 0..Nr
- rk_data  out  128  round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}
- rk_valid  out  1  rk_data valid, one cycle after rk_rd_en

## Operation
- Constants: Nk=4/6/8, Nr=Nk+6, Nw=4*(Nr+1)=44/52/60.
- States: IDLE, EXPAND.
- IDLE + start + legal key_len:
  - Store w[0..Nk-1] from key_in.
  - Set i=Nk, j=0 (i mod Nk), rcon=8'h01.
  - Latch Nk/Nr, clear keys_valid, go to EXPAND.
- Illegal start (key_len=11, or key size > MAX_KEY_BITS): err pulses; storage, num_rounds and keys_valid are unchanged.
- start while busy is ignored; no err.
- EXPAND, once per cycle: temp=w[i-1].
  - j==0: temp=SubWord(RotWord(temp)) ^ {rcon,24'h0}; then rcon=xtime(rcon) (0x80→0x1b).
  - Nk==8 and j==4: temp=SubWord(temp).
  - Write w[i]=w[i-Nk]^temp; i++; j wraps at Nk-1 to 0.
- After the write of w[Nw-1]: return to IDLE, pulse done, set keys_valid, update num_rounds.
- No division anywhere; j and rcon are counters.
- Read port:
  - rk_rd_round>num_rounds, or keys_valid=0 → rk_data=0, rk_valid still pulses.
  - Reads during EXPAND return zeros.
- Reset: state IDLE, storage cleared, all outputs 0.
  - Reset mid-EXPAND aborts the operation; no done pulse.
  - keys_valid stays 0 until a full expansion completes.

## Timing
- Start accepted at edge T; busy high from T+1.
- First generated word is written at T+1; last word at T+(Nw-Nk), i.e. T+40/46/52.
- done and keys_valid high, busy low, visible in the cycle after the last write.
- Start-to-done latency: 41/47/53 cycles for 128/192/256.
- A new start in the done cycle is accepted (state is IDLE).
- rk_valid and rk_data are registered, with 1-cycle latency; back-to-back reads every cycle.
- rk_data holds its value when rk_rd_en=0; rk_valid=0.
- err: one-cycle pulse the cycle after the illegal start.

## Structure
- Package aes_pkg: key_len encoding, NK/NR/NW constants per mode, xtime function, S-box table function.
- Sub-module aes_sbox: combinational byte S-box. Four instances form SubWord; this sub-module is shared with the round datapath.
- Word storage is a register array indexed by word number; the read port muxes four consecutive words.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c → done at T+41; round 0 = key; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; num_rounds=10.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → done at T+47; round 12 = e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → done at T+53; round 14 = fe4890d1e6188d0b046df344706c631e.
- key_len=11, or 256-bit key with MAX_KEY_BITS=128 → err pulse; no busy; previous schedule and keys_valid intact.
- rst_n low at T+20 of an AES-256 run → all outputs 0, no done. Rerun AES-128 → correct schedule.
- start during EXPAND ignored (done still at T+41). Read round 11 after AES-128 → rk_data=0, rk_valid=1. Back-to-back reads of rounds 0..10 return correct keys, each one cycle later.
